// File: rtl/fir_pkg.sv
// Shared defaults and elaboration-time helpers for the shift-coefficient FIR.
package fir_pkg;

  localparam int FIR_DATA_W  = 8;
  localparam int FIR_TAPS    = 5;
  localparam int FIR_SHIFT_W = 3;

  // Ceiling log2; used for address and output growth widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((32'sd1 << result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // Power-on shift for tap k: older taps are attenuated less, clamped to the field maximum.
  function automatic int sh_reset(input int taps, input int k, input int shift_w);
    int limit;
    limit = (32'sd1 << shift_w) - 32'sd1;
    if ((taps - k) < limit) begin
      return taps - k;
    end else begin
      return limit;
    end
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: tap[0] takes the new sample, every other tap takes its
// younger neighbour on each shift. Flattened with tap[0] in the low bits.
module fir_delay_line #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     clr,
  input  logic [DATA_W-1:0]        din,
  output logic [TAPS*DATA_W-1:0]   taps
);

  logic [TAPS*DATA_W-1:0] taps_r;

  // Delay-line storage: async clear on reset, flush on clr, shift on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taps_r <= {(TAPS*DATA_W){1'b0}};
    end else if (clr) begin
      taps_r <= {(TAPS*DATA_W){1'b0}};
    end else if (shift_en) begin
      taps_r <= {taps_r[(TAPS-1)*DATA_W-1:0], din};
    end else begin
      taps_r <= taps_r;
    end
  end

  assign taps = taps_r;

endmodule

// File: rtl/fir_shift_pipe.sv
// Multiplier-free FIR: each tap is right-shifted by a programmable amount and
// the shifted taps are summed into a registered, lossless result with a
// valid/ready handshake on both sides.
module fir_shift_pipe
  import fir_pkg::*;
#(
  parameter  int DATA_W  = FIR_DATA_W,
  parameter  int TAPS    = FIR_TAPS,
  parameter  int SHIFT_W = FIR_SHIFT_W,
  localparam int AW      = clog2(TAPS),
  localparam int OUT_W   = DATA_W + clog2(TAPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  x,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic [OUT_W-1:0]   dataout,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [TAPS*DATA_W-1:0] taps_s;
  logic [DATA_W-1:0]      tap_new_s [TAPS];
  logic [SHIFT_W-1:0]     sh_r [TAPS];
  logic [OUT_W-1:0]       sum_s;
  logic [OUT_W-1:0]       dataout_r;
  logic                   out_valid_r;
  logic                   in_ready_s;
  logic                   accept_s;
  logic                   unused_last_tap_s;

  // A new sample may enter whenever the output slot is free or being drained,
  // except during a flush.
  assign in_ready_s = (!out_valid_r || out_ready) && !clr;
  assign accept_s   = in_valid && in_ready_s;

  assign in_ready  = in_ready_s;
  assign dataout   = dataout_r;
  assign out_valid = out_valid_r;

  fir_delay_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_delay_line (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept_s),
    .clr      (clr),
    .din      (x),
    .taps     (taps_s)
  );

  // The oldest stored tap drops off the end on a shift and is never summed.
  assign unused_last_tap_s = ^taps_s[TAPS*DATA_W-1 -: DATA_W];

  // Tap values as they will stand after this accept (x enters at tap 0).
  always_comb begin
    tap_new_s[0] = x;
    for (int k = 1; k < TAPS; k++) begin
      tap_new_s[k] = taps_s[(k-1)*DATA_W +: DATA_W];
    end
  end

  // Adder tree over shifted taps; OUT_W holds TAPS full-scale samples.
  always_comb begin
    sum_s = {OUT_W{1'b0}};
    for (int k = 0; k < TAPS; k++) begin
      sum_s = sum_s + OUT_W'(tap_new_s[k] >> sh_r[k]);
    end
  end

  // Coefficient file: reset to the default taper, written by cfg_we.
  // Out-of-range addresses match no entry; clr leaves coefficients alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        sh_r[k] <= SHIFT_W'(sh_reset(TAPS, k, SHIFT_W));
      end
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (cfg_we && (cfg_addr == AW'(k))) begin
          sh_r[k] <= cfg_shift;
        end else begin
          sh_r[k] <= sh_r[k];
        end
      end
    end
  end

  // Output slot: load on accept, empty on consume, hold under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dataout_r   <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (clr) begin
      dataout_r   <= {OUT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      dataout_r   <= sum_s;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      dataout_r   <= dataout_r;
      out_valid_r <= 1'b0;
    end else begin
      dataout_r   <= dataout_r;
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_fir_shift_pipe.sv
// Self-checking bench for fir_shift_pipe: table vectors, hand sequences for
// backpressure / flush / config / reset, and a randomised handshake run.
// Expected results are queued on accept and compared when the DUT delivers.
module tb_fir_shift_pipe;

  localparam int DATA_W  = 8;
  localparam int TAPS    = 5;
  localparam int SHIFT_W = 3;
  localparam int AW      = 3;
  localparam int OUT_W   = 11;

  logic               clk;
  logic               rst;
  logic [DATA_W-1:0]  x;
  logic               in_valid;
  logic               in_ready;
  logic               clr;
  logic               cfg_we;
  logic [AW-1:0]      cfg_addr;
  logic [SHIFT_W-1:0] cfg_shift;
  logic [OUT_W-1:0]   dataout;
  logic               out_valid;
  logic               out_ready;

  int n_chk;
  int n_fail;
  int exp_q[$];
  int mon_e;
  int m_taps [TAPS];
  int m_sh   [TAPS];

  typedef struct {
    logic [7:0] x;
    int         exp;
  } vec_t;

  vec_t vecs [11];

  fir_shift_pipe #(
    .DATA_W  (DATA_W),
    .TAPS    (TAPS),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .clr       (clr),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_shift (cfg_shift),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) m_taps[k] = 0;
  endtask

  task automatic model_reset();
    model_clear();
    for (int k = 0; k < TAPS; k++) m_sh[k] = ((TAPS - k) < 7) ? (TAPS - k) : 7;
  endtask

  task automatic model_step(input int xv, output int r);
    for (int k = TAPS - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
    m_taps[0] = xv;
    r = 0;
    for (int k = 0; k < TAPS; k++) r = r + (m_taps[k] >> m_sh[k]);
  endtask

  // One clock of stimulus; inputs change 1 ns after the rising edge and the
  // handshake is observed on the falling edge.
  task automatic tick(input logic v, input logic [7:0] xv, input logic ordy,
                      input logic c, input logic we, input logic [2:0] a,
                      input logic [2:0] s, input logic use_exp, input int expv,
                      input logic must);
    logic acc;
    int   r;
    in_valid  = v;
    x         = xv;
    out_ready = ordy;
    clr       = c;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_shift = s;
    @(negedge clk);
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    if (must) check("accept", int'(acc), 1);
    if (c) begin
      model_clear();
      if (!ordy) exp_q.delete();
    end else if (acc) begin
      model_step(int'(xv), r);
      exp_q.push_back(use_exp ? expv : r);
    end
    if (we && (a < 3'd5)) m_sh[a] = int'(s);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare each consumed result against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", int'(dataout), -1);
      end else begin
        mon_e = exp_q.pop_front();
        check("dataout", int'(dataout), mon_e);
      end
    end
  end

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = 8'd0;
    clr       = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_shift = 3'd0;
    out_ready = 1'b1;
    model_reset();

    // Impulse then full-scale ramp, default coefficients 5,4,3,2,1.
    vecs[0]  = '{8'd128, 4};
    vecs[1]  = '{8'd0,   8};
    vecs[2]  = '{8'd0,   16};
    vecs[3]  = '{8'd0,   32};
    vecs[4]  = '{8'd0,   64};
    vecs[5]  = '{8'd0,   0};
    vecs[6]  = '{8'd255, 7};
    vecs[7]  = '{8'd255, 22};
    vecs[8]  = '{8'd255, 53};
    vecs[9]  = '{8'd255, 116};
    vecs[10] = '{8'd255, 243};

    // Power-on reset.
    #2 rst = 1'b0;
    #1;
    check("reset_dataout", int'(dataout), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      tick(1'b1, vecs[i].x, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, vecs[i].exp, 1'b1);
    end

    // Backpressure: result 236 must hold while out_ready is low.
    tick(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 236, 1'b1);
    in_valid  = 1'b1;
    x         = 8'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_hold", int'(dataout), 236);
      @(posedge clk);
      #1;
    end
    tick(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 221, 1'b1);

    // Flush with a sample offered: no accept, output emptied, history zeroed.
    tick(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 0, 1'b0);
    tick(1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 7, 1'b1);
    tick(1'b1, 8'd255, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 22, 1'b1);
    in_valid = 1'b1;
    x        = 8'd99;
    clr      = 1'b1;
    @(negedge clk);
    check("clr_in_ready", int'(in_ready), 0);
    model_clear();
    @(posedge clk);
    #1;
    check("clr_out_valid", int'(out_valid), 0);
    tick(1'b1, 8'd64, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 2, 1'b1);

    // Coefficient write alongside an accept uses the old shift.
    tick(1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 0, 1'b0);
    tick(1'b1, 8'd100, 1'b1, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 3, 1'b1);
    tick(1'b1, 8'd100, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 106, 1'b1);

    // Asynchronous reset mid-stream with a result pending.
    tick(1'b1, 8'd50, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 0, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_dataout", int'(dataout), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    tick(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 3'd7, 3'd0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, vecs[i].x, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, vecs[i].exp, 1'b1);
    end

    // Random handshake traffic checked against the reference model.
    for (int i = 0; i < 80; i++) begin
      tick(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'b0, 0, 1'b0);
    end

    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 0, 1'b0);
    end
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_shift_pipe.md
FIR_SHIFT_PIPE -- requirements
Module: fir_shift_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning input sample width.
REQ-002 The block SHALL have parameter TAPS, default 5, meaning number of filter taps (2..16).
REQ-003 The block SHALL have parameter SHIFT_W, default 3, meaning per-tap right-shift coefficient width.
REQ-004 The block SHALL have derived localparam OUT_W = DATA_W + clog2(TAPS), meaning lossless output width.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, meaning asynchronous, active-low reset.
REQ-007 The block SHALL have port x, input, DATA_W bits, meaning the unsigned input sample.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning x is valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts x this cycle.
REQ-010 The block SHALL have port clr, input, 1 bit, meaning synchronous flush of delay line and output.
REQ-011 The block SHALL have port cfg_we, input, 1 bit, meaning coefficient write strobe.
REQ-012 The block SHALL have port cfg_addr, input, clog2(TAPS) bits, meaning tap index to write.
REQ-013 The block SHALL have port cfg_shift, input, SHIFT_W bits, meaning new shift amount for tap cfg_addr.
REQ-014 The block SHALL have port dataout, output, OUT_W bits, meaning the registered filter result.
REQ-015 The block SHALL have port out_valid, output, 1 bit, meaning dataout holds a valid result.
REQ-016 The block SHALL have port out_ready, input, 1 bit, meaning downstream consumes dataout.

Function
REQ-017 Accept SHALL occur when in_valid and in_ready are both 1.
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !clr, combinationally.
REQ-019 On accept, tap[0] SHALL load x and tap[k] SHALL load the old tap[k-1] for k = 1..TAPS-1; otherwise taps hold.
REQ-020 The result SHALL be sum over k of (t[k] >> sh[k]), using the new tap values (t[0] = x), zero-extended to OUT_W; no overflow is possible and none SHALL be truncated.
REQ-021 dataout SHALL register the result and out_valid SHALL rise on the cycle after accept (latency 1); one accept per cycle is sustained while out_ready = 1.
REQ-022 When out_valid = 1 and out_ready = 0, dataout and out_valid SHALL hold, and no accept SHALL occur.
REQ-023 out_valid SHALL clear after a consume (out_valid && out_ready) with no simultaneous accept; consume plus accept SHALL load the new result.
REQ-024 cfg_we SHALL write sh[cfg_addr] at the clock edge; cfg_addr >= TAPS SHALL be ignored.
REQ-025 An accept coinciding with cfg_we SHALL use the pre-write shift values.
REQ-026 clr SHALL zero all taps and out_valid on the next edge, with priority over accept; shift coefficients SHALL be unaffected.

Reset
REQ-027 rst low SHALL immediately zero all taps, dataout and out_valid.
REQ-028 rst low SHALL immediately set sh[k] = min(TAPS-k, 2^SHIFT_W-1).
REQ-029 Reset asserted mid-stream SHALL discard any pending output; the first post-reset result SHALL see zero history.

Structure
REQ-030 Package fir_pkg SHALL hold the default DATA_W, TAPS and SHIFT_W and a clog2 function.
REQ-031 The delay line SHALL be a sub-module fir_delay_line (parameters DATA_W and TAPS; inputs shift-enable and clr; output the flattened tap vector).
REQ-032 The coefficient register file, adder tree and output register SHALL live in fir_shift_pipe.

Verification (defaults; sh = 5,4,3,2,1)
REQ-033 Impulse: 128 followed by zeros, out_ready = 1 -> dataout = 4, 8, 16, 32, 64, 0, each one cycle after its accept.
REQ-034 Full scale: 255 for five accepts -> dataout = 7, 22, 53, 116, 243.
REQ-035 Backpressure: out_ready = 0 with out_valid = 1 -> in_ready = 0 and dataout stable for 3 cycles; the next sample is accepted on the cycle out_ready returns to 1.
REQ-036 Config: write sh[0] = 0 concurrent with an accept of 100 -> that result uses shift 5 (3); the next accept of 100 gives 100 + (100 >> 4) = 106.
REQ-037 clr with in_valid = 1 after two 255 samples -> no accept, out_valid = 0; the next accept of 64 -> dataout = 2.
REQ-038 rst pulsed low asynchronously mid-stream -> outputs zero immediately, sh returns to 5,4,3,2,1, cfg_addr = 7 writes are ignored.
